// File: rtl/sysid_boot_checker_pkg.sv
// sysid_pkg: shared state encoding, address map and counter widths for the system-ID boot checker
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, EVAL, PASS, FAIL} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int ATTEMPT_W = 4;
  localparam int TMR_W = 8;
  localparam int SYSID_DATA_W = 32;
endpackage

// File: rtl/sysid_boot_checker_if.sv
// sysid_boot_checker_if: Avalon-MM read port between the boot checker and the system-ID slave
interface sysid_boot_checker_if;
  import sysid_pkg::*;
  logic avm_address;
  logic avm_read;
  logic avm_waitrequest;
  logic [SYSID_DATA_W-1:0] avm_readdata;
  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads system-ID words 0/1 after reset or on start, compares, retries, reports pass/fail
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = '0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS = '0,
  parameter bit CHECK_TS = 1'b1,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  sysid_boot_checker_if.master avm,
  output logic busy,
  output logic pass,
  output logic fail,
  output logic timeout,
  output logic [SYSID_DATA_W-1:0] id_q,
  output logic [SYSID_DATA_W-1:0] ts_q,
  output logic [ATTEMPT_W-1:0] attempts
);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LATENCY);
  localparam logic [ATTEMPT_W:0] MAX_R = (ATTEMPT_W + 1)'(MAX_RETRY);
  state_t r_state;
  logic r_booted;
  logic [TMR_W-1:0] r_cnt;
  logic w_match;
  logic w_retry;
  assign w_match = (id_q == EXPECTED_ID) && (!CHECK_TS || ts_q == EXPECTED_TS);
  assign w_retry = {1'b0, attempts} <= MAX_R;
  assign avm.avm_read = (r_state == REQ_ID) || (r_state == REQ_TS);
  assign avm.avm_address = (r_state == REQ_TS || r_state == LAT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  // r_cnt is the waitrequest timer in REQ_x and the latency counter in LAT_x
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_booted <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      id_q     <= '0;
      ts_q     <= '0;
      attempts <= '0;
    end else begin
      case (r_state)
        IDLE, PASS, FAIL: begin
          if (start || !r_booted) begin
            r_state  <= REQ_ID;
            r_booted <= 1'b1;
            r_cnt    <= TMR_LOAD;
            busy     <= 1'b1;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            attempts <= ATTEMPT_W'(1);
          end
        end
        REQ_ID: begin
          if (!avm.avm_waitrequest) begin
            if (READ_LATENCY == 0) begin
              id_q    <= avm.avm_readdata;
              r_state <= REQ_TS;
              r_cnt   <= TMR_LOAD;
            end else begin
              r_state <= LAT_ID;
              r_cnt   <= LAT_LOAD;
            end
          end else if (r_cnt == TMR_W'(1)) begin
            r_state <= FAIL;
            busy    <= 1'b0;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - TMR_W'(1);
          end
        end
        LAT_ID: begin
          if (r_cnt == TMR_W'(1)) begin
            id_q    <= avm.avm_readdata;
            r_state <= REQ_TS;
            r_cnt   <= TMR_LOAD;
          end else begin
            r_cnt <= r_cnt - TMR_W'(1);
          end
        end
        REQ_TS: begin
          if (!avm.avm_waitrequest) begin
            if (READ_LATENCY == 0) begin
              ts_q    <= avm.avm_readdata;
              r_state <= EVAL;
            end else begin
              r_state <= LAT_TS;
              r_cnt   <= LAT_LOAD;
            end
          end else if (r_cnt == TMR_W'(1)) begin
            r_state <= FAIL;
            busy    <= 1'b0;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - TMR_W'(1);
          end
        end
        LAT_TS: begin
          if (r_cnt == TMR_W'(1)) begin
            ts_q    <= avm.avm_readdata;
            r_state <= EVAL;
          end else begin
            r_cnt <= r_cnt - TMR_W'(1);
          end
        end
        EVAL: begin
          if (w_match) begin
            r_state <= PASS;
            busy    <= 1'b0;
            pass    <= 1'b1;
          end else if (w_retry) begin
            r_state  <= REQ_ID;
            r_cnt    <= TMR_LOAD;
            attempts <= attempts + ATTEMPT_W'(1);
          end else begin
            r_state <= FAIL;
            busy    <= 1'b0;
            fail    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule
